ex_stage: RTL

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and applies operand forwarding, immediate extension, ALU operation and destination-register selection. It also holds an iterative multiply/divide unit with HI/LO registers, and raises a stall when a HI/LO-dependent instruction meets a busy unit. Its combinational results feed the EX/MEM pipeline register, and its stall output holds PC, IF/ID and ID/EX.

---
 rtl/ex_stage_if.sv | 43 ++++
 rtl/ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM-facing outputs of the execute stage, bundled as one interface.
// The slave side is the execute stage; the master side is whatever drives ID/EX and samples EX/MEM.
interface ex_stage_if;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] pc_add4;
    logic [4:0]  ex_ctrl;
    logic [2:0]  m_in;
    logic [1:0]  wb_in;
    logic        ext_op;
    logic [15:0] imm16;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] exmem_result;
    logic [31:0] memwb_data;

    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] link_addr;
    logic [4:0]  dest_reg;
    logic [2:0]  m_out;
    logic [1:0]  wb_out;
    logic        zero;
    logic        overflow;
    logic        stall;
    logic        md_busy;

    modport master (
        output busA, busB, pc_add4, ex_ctrl, m_in, wb_in, ext_op, imm16, rt, rd,
               fwd_a, fwd_b, exmem_result, memwb_data,
        input  alu_result, store_data, link_addr, dest_reg, m_out, wb_out,
               zero, overflow, stall, md_busy
    );

    modport slave (
        input  busA, busB, pc_add4, ex_ctrl, m_in, wb_in, ext_op, imm16, rt, rd,
               fwd_a, fwd_b, exmem_result, memwb_data,
        output alu_result, store_data, link_addr, dest_reg, m_out, wb_out,
               zero, overflow, stall, md_busy
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, iterative mult/div with HI/LO, and HI/LO hazard stall.
// Define EX_DIV_EN to build the restoring divider; without it div/divu are no-ops.
module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  ex
);
    localparam int CW = $clog2(MD_CYCLES);
    localparam logic [CW-1:0] LAST_STEP = CW'(MD_CYCLES - 1);

    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU = 6'b011011;
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t      state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [63:0]    acc_reg, acc_next;
    logic [31:0]    mag_b_reg, mag_b_next;
    logic           neg_q_reg, neg_q_next;
    logic [31:0]    hi_reg, hi_next;
    logic [31:0]    lo_reg, lo_next;

    logic [31:0] src_a, src_b, ext_imm, op_b;
    logic [31:0] add_res, sub_res, alu_res;
    logic        add_ovf, sub_ovf, ovf;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        is_rtype;
    logic        op_mult, op_div, div_live, op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic        hilo_user, md_idle, md_start, md_signed;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;

    always_comb begin
        case (ex.fwd_a)
            2'b01:   src_a = ex.exmem_result;
            2'b10:   src_a = ex.memwb_data;
            default: src_a = ex.busA;
        endcase
        case (ex.fwd_b)
            2'b01:   src_b = ex.exmem_result;
            2'b10:   src_b = ex.memwb_data;
            default: src_b = ex.busB;
        endcase
    end

    assign ext_imm = ex.ext_op ? {{16{ex.imm16[15]}}, ex.imm16} : {16'd0, ex.imm16};
    assign op_b    = ex.ex_ctrl[3] ? ext_imm : src_b;
    assign funct   = ex.imm16[5:0];
    assign shamt   = ex.imm16[10:6];

    assign add_res = src_a + op_b;
    assign sub_res = src_a - op_b;
    assign add_ovf = (src_a[31] == op_b[31]) && (add_res[31] != src_a[31]);
    assign sub_ovf = (src_a[31] != op_b[31]) && (sub_res[31] != src_a[31]);

    assign is_rtype = (ex.ex_ctrl[2:0] == 3'b010);
    assign op_mult  = is_rtype && (funct == F_MULT || funct == F_MULTU);
    assign op_div   = is_rtype && (funct == F_DIV  || funct == F_DIVU);
    assign op_mthi  = is_rtype && (funct == F_MTHI);
    assign op_mtlo  = is_rtype && (funct == F_MTLO);
    assign op_mfhi  = is_rtype && (funct == F_MFHI);
    assign op_mflo  = is_rtype && (funct == F_MFLO);
`ifdef EX_DIV_EN
    assign div_live = op_div;
`else
    assign div_live = 1'b0;
`endif

    assign hilo_user = op_mult | div_live | op_mthi | op_mtlo | op_mfhi | op_mflo;
    assign md_idle   = (state_reg == IDLE);
    assign md_start  = reset && md_idle && (op_mult || div_live);

    // Odd funct codes (multu/divu) are the unsigned variants.
    assign md_signed = ~funct[0];
    assign sign_a    = md_signed & src_a[31];
    assign sign_b    = md_signed & src_b[31];
    assign mag_a     = sign_a ? -src_a : src_a;
    assign mag_b     = sign_b ? -src_b : src_b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, mag_b_reg} : 33'd0);
    assign mul_step = {mul_sum, acc_reg[31:1]};

`ifdef EX_DIV_EN
    logic        op_div_reg, op_div_next;
    logic        neg_r_reg, neg_r_next;
    logic        div_zero_reg, div_zero_next;
    logic [31:0] dividend_reg, dividend_next;
    logic [32:0] div_tmp, div_diff;
    logic        div_ge;
    logic [63:0] div_step;

    // Restoring step: acc = {remainder, dividend bits shifting into quotient}.
    assign div_tmp  = {acc_reg[63:32], acc_reg[31]};
    assign div_diff = div_tmp - {1'b0, mag_b_reg};
    assign div_ge   = (div_tmp >= {1'b0, mag_b_reg});
    assign div_step = {(div_ge ? div_diff[31:0] : div_tmp[31:0]), acc_reg[30:0], div_ge};
`endif

    always_ff @(negedge clk) begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        acc_reg   <= acc_next;
        mag_b_reg <= mag_b_next;
        neg_q_reg <= neg_q_next;
        hi_reg    <= hi_next;
        lo_reg    <= lo_next;
`ifdef EX_DIV_EN
        op_div_reg   <= op_div_next;
        neg_r_reg    <= neg_r_next;
        div_zero_reg <= div_zero_next;
        dividend_reg <= dividend_next;
`endif
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        mag_b_next = mag_b_reg;
        neg_q_next = neg_q_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
`ifdef EX_DIV_EN
        op_div_next   = op_div_reg;
        neg_r_next    = neg_r_reg;
        div_zero_next = div_zero_reg;
        dividend_next = dividend_reg;
`endif
        if (!reset) begin
            state_next = IDLE;
            cnt_next   = '0;
            hi_next    = '0;
            lo_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (md_start) begin
                        state_next = BUSY;
                        cnt_next   = '0;
                        acc_next   = {32'd0, mag_a};
                        mag_b_next = mag_b;
                        neg_q_next = sign_a ^ sign_b;
`ifdef EX_DIV_EN
                        op_div_next   = div_live;
                        neg_r_next    = sign_a;
                        div_zero_next = (src_b == 32'd0);
                        dividend_next = src_a;
`endif
                    end else if (op_mthi) begin
                        hi_next = src_a;
                    end else if (op_mtlo) begin
                        lo_next = src_a;
                    end
                end
                BUSY: begin
                    acc_next = mul_step;
`ifdef EX_DIV_EN
                    if (op_div_reg)
                        acc_next = div_step;
`endif
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP)
                        state_next = DONE;
                end
                DONE: begin
                    state_next         = IDLE;
                    {hi_next, lo_next} = neg_q_reg ? -acc_reg : acc_reg;
`ifdef EX_DIV_EN
                    if (op_div_reg) begin
                        lo_next = neg_q_reg ? -acc_reg[31:0]  : acc_reg[31:0];
                        hi_next = neg_r_reg ? -acc_reg[63:32] : acc_reg[63:32];
                        if (div_zero_reg) begin
                            lo_next = '1;
                            hi_next = dividend_reg;
                        end
                    end
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (ex.ex_ctrl[2:0])
            3'b000: begin alu_res = add_res; ovf = add_ovf; end
            3'b001: begin alu_res = sub_res; ovf = sub_ovf; end
            3'b010: begin
                case (funct)
                    F_ADD:   begin alu_res = add_res; ovf = add_ovf; end
                    F_ADDU:  alu_res = add_res;
                    F_SUB:   begin alu_res = sub_res; ovf = sub_ovf; end
                    F_SUBU:  alu_res = sub_res;
                    F_AND:   alu_res = src_a & op_b;
                    F_OR:    alu_res = src_a | op_b;
                    F_XOR:   alu_res = src_a ^ op_b;
                    F_NOR:   alu_res = ~(src_a | op_b);
                    F_SLT:   alu_res = {31'd0, $signed(src_a) < $signed(op_b)};
                    F_SLTU:  alu_res = {31'd0, src_a < op_b};
                    F_SLL:   alu_res = op_b << shamt;
                    F_SRL:   alu_res = op_b >> shamt;
                    F_SRA:   alu_res = 32'($signed(op_b) >>> shamt);
                    F_MFHI:  alu_res = hi_reg;
                    F_MFLO:  alu_res = lo_reg;
                    default: alu_res = '0;
                endcase
            end
            3'b011: alu_res = src_a & op_b;
            3'b100: alu_res = src_a | op_b;
            3'b101: alu_res = {31'd0, $signed(src_a) < $signed(op_b)};
            3'b110: alu_res = {ex.imm16, 16'd0};
            default: alu_res = src_a ^ op_b;
        endcase
    end

    assign ex.alu_result = alu_res;
    assign ex.overflow   = ovf;
    assign ex.zero       = (alu_res == 32'd0);
    assign ex.store_data = src_b;
    assign ex.link_addr  = ex.pc_add4;
    assign ex.dest_reg   = ex.ex_ctrl[4] ? ex.rd : ex.rt;
    assign ex.stall      = reset && hilo_user && !md_idle;
    assign ex.md_busy    = reset && !md_idle;
    assign ex.m_out      = (ex.stall || !reset) ? 3'd0 : ex.m_in;
    // mult/div results land in HI/LO, never in a GPR.
    assign ex.wb_out     = (ex.stall || !reset || op_mult || op_div) ? 2'd0 : ex.wb_in;
endmodule
